// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter between the RV32I core and the host/debug port.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_CORE = 2'd0,
    S_HOST = 2'd1,
    S_ACK  = 2'd2
  } arb_state_e;

  // Bits needed to hold 0..max_val inclusive; never narrower than one bit.
  function automatic int starve_cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating counter of core memory cycles granted while a host request waits.
module dmem_arb_starve_cnt #(
  parameter int MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  import dmem_arb_pkg::*;

  localparam int             W     = starve_cnt_w(MAX);
  localparam logic [W-1:0]   MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment so a host grant always restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_max = (cnt_q == MAX_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates data_memory between the core load/store port and the host/debug port.
// Define DMEM_ARB_HOST_WRITE_EN to let the host write; otherwise host accesses are reads.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_mem_read,
  input  logic              core_mem_write,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_host
);
  import dmem_arb_pkg::*;

  arb_state_e        state_q, state_d;
  logic              host_ack_q, host_ack_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  logic core_active;
  logic host_wr;
  logic host_rd;
  logic starve_inc;
  logic starve_clr;
  logic starve_at_max;

  assign core_active = core_mem_read | core_mem_write;

`ifdef DMEM_ARB_HOST_WRITE_EN
  assign host_wr = host_we;
`else
  logic unused_host_we;
  assign unused_host_we = host_we;
  assign host_wr        = 1'b0;
`endif
  assign host_rd = ~host_wr;

  assign starve_inc = (state_q == S_CORE) && host_req && core_active;
  assign starve_clr = (state_q == S_HOST) || !host_req;

  dmem_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );

  always_comb begin
    state_d      = state_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    mem_read     = core_mem_read;
    mem_write    = core_mem_write;
    mem_addr     = core_addr;
    mem_wdata    = core_wdata;
    core_rdata   = mem_rdata;
    core_stall   = 1'b0;
    grant_host   = 1'b0;

    case (state_q)
      S_CORE: begin
        if (host_req && (!core_active || starve_at_max)) begin
          state_d = S_HOST;
        end
      end
      S_HOST: begin
        mem_read   = host_rd;
        mem_write  = host_wr;
        mem_addr   = host_addr;
        mem_wdata  = host_wdata;
        core_rdata = '0;
        core_stall = core_active;
        grant_host = 1'b1;
        host_ack_d = 1'b1;
        if (host_rd) begin
          host_rdata_d = mem_rdata;
        end
        state_d = S_ACK;
      end
      // Ack cycle hands memory straight back to the core; host_req is not looked at.
      S_ACK: begin
        state_d = S_CORE;
      end
      default: begin
        state_d = S_CORE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_CORE;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data_memory (combinational read, clocked write).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        core_mem_read = 1'b0;
  logic        core_mem_write = 1'b0;
  logic [31:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [31:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        grant_host;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  int          write_cnt = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .core_mem_read  (core_mem_read),
    .core_mem_write (core_mem_write),
    .core_addr      (core_addr),
    .core_wdata     (core_wdata),
    .core_rdata     (core_rdata),
    .core_stall     (core_stall),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_ack       (host_ack),
    .host_rdata     (host_rdata),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .grant_host     (grant_host)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_idx] <= pre_data;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      write_cnt          <= write_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_idx  = addr[9:2];
    pre_data = data;
    step();
    pre_we   = 1'b0;
  endtask

  int          wc0;
  int          first_stall;
  int          stall_cnt;
  int          first_ack;
  logic [31:0] stall_rdata;
  logic [8:0]  ack_map;
  logic [31:0] word;

  initial begin
    preload(32'h10, 32'hDEADBEEF);
    preload(32'h30, 32'hA5A5A5A5);
    preload(32'h50, 32'h11111111);

    // Reset state; memory port follows the core even while held in reset.
    core_mem_read = 1'b1;
    core_addr     = 32'h44;
    @(negedge clk);
    check_eq("rst_host_ack", {31'd0, host_ack}, 32'd0);
    check_eq("rst_host_rdata", host_rdata, 32'd0);
    check_eq("rst_grant_host", {31'd0, grant_host}, 32'd0);
    check_eq("rst_core_stall", {31'd0, core_stall}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h44);
    check_eq("rst_mem_read", {31'd0, mem_read}, 32'd1);
    step();
    rst           = 1'b1;
    core_mem_read = 1'b0;
    step();

    // Host read with core idle: request cycle N, access N+1, ack N+2.
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 32'h10;
    @(negedge clk);
    check_eq("rd_n_grant", {31'd0, grant_host}, 32'd0);
    step();
    @(negedge clk);
    check_eq("rd_n1_grant", {31'd0, grant_host}, 32'd1);
    check_eq("rd_n1_mem_addr", mem_addr, 32'h10);
    check_eq("rd_n1_mem_read", {31'd0, mem_read}, 32'd1);
    check_eq("rd_n1_ack", {31'd0, host_ack}, 32'd0);
    step();
    @(negedge clk);
    check_eq("rd_n2_ack", {31'd0, host_ack}, 32'd1);
    check_eq("rd_n2_rdata", host_rdata, 32'hDEADBEEF);
    check_eq("rd_n2_grant", {31'd0, grant_host}, 32'd0);
    step();
    host_req = 1'b0;
    @(negedge clk);
    check_eq("rd_after_ack", {31'd0, host_ack}, 32'd0);
    step();

`ifdef DMEM_ARB_HOST_WRITE_EN
    // Host write 0x20, then the core loads it back.
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 32'h20;
    host_wdata = 32'h12345678;
    step();
    @(negedge clk);
    check_eq("wr_mem_write", {31'd0, mem_write}, 32'd1);
    step();
    @(negedge clk);
    check_eq("wr_ack", {31'd0, host_ack}, 32'd1);
    check_eq("wr_rdata_held", host_rdata, 32'hDEADBEEF);
    step();
    host_req = 1'b0;
    host_we  = 1'b0;
`else
    // Read-only host: a write request must not touch memory but still completes as a read.
    wc0        = write_cnt;
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 32'h30;
    host_wdata = 32'hFFFFFFFF;
    step();
    @(negedge clk);
    check_eq("ro_mem_write", {31'd0, mem_write}, 32'd0);
    step();
    @(negedge clk);
    check_eq("ro_ack", {31'd0, host_ack}, 32'd1);
    check_eq("ro_rdata", host_rdata, 32'hA5A5A5A5);
    step();
    host_req = 1'b0;
    host_we  = 1'b0;
    word = mem[8'h0C];
    check_eq("ro_mem_unchanged", word, 32'hA5A5A5A5);
    check_eq("ro_write_cnt", write_cnt - wc0, 32'd0);
    // Core stores 0x20 itself so the load below has known data.
    core_mem_write = 1'b1;
    core_addr      = 32'h20;
    core_wdata     = 32'h12345678;
    @(negedge clk);
    check_eq("core_sw_mem_write", {31'd0, mem_write}, 32'd1);
    step();
    core_mem_write = 1'b0;
`endif
    core_mem_read = 1'b1;
    core_addr     = 32'h20;
    @(negedge clk);
    check_eq("core_lw_rdata", core_rdata, 32'h12345678);
    check_eq("core_lw_stall", {31'd0, core_stall}, 32'd0);
    step();

    // Core busy every cycle with host pending: starvation bound forces one host slot.
    first_stall = -1;
    stall_cnt   = 0;
    first_ack   = -1;
    stall_rdata = 32'hFFFFFFFF;
    host_req    = 1'b1;
    host_we     = 1'b0;
    host_addr   = 32'h30;
    for (int k = 0; k < 16; k++) begin
      core_mem_read  = (k % 2 == 0);
      core_mem_write = (k % 2 == 1);
      core_addr      = (k % 2 == 0) ? 32'h10 : 32'h40;
      core_wdata     = k;
      @(negedge clk);
      if (core_stall) begin
        stall_cnt++;
        if (first_stall < 0) begin
          first_stall = k;
          stall_rdata = core_rdata;
        end
      end
      if (host_ack && first_ack < 0) first_ack = k;
      step();
      if (first_ack >= 0) host_req = 1'b0;
    end
    core_mem_read  = 1'b0;
    core_mem_write = 1'b0;
    check_eq("starve_first_stall", first_stall, 32'd9);
    check_eq("starve_stall_cnt", stall_cnt, 32'd1);
    check_eq("starve_ack_cycle", first_ack, 32'd10);
    check_eq("starve_stall_rdata", stall_rdata, 32'd0);
    check_eq("starve_host_rdata", host_rdata, 32'hA5A5A5A5);
    step();

    // Back-to-back host reads with req held: acks every third cycle.
    ack_map   = '0;
    host_req  = 1'b1;
    host_addr = 32'h10;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      ack_map[k] = host_ack;
      step();
    end
    host_req = 1'b0;
    check_eq("b2b_ack_map", {23'd0, ack_map}, 32'h124);
    check_eq("b2b_rdata", host_rdata, 32'hDEADBEEF);
    step();
    step();

    // Reset asserted during the host-write cycle aborts the write.
    wc0        = write_cnt;
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 32'h50;
    host_wdata = 32'hCAFEF00D;
    step();
    @(negedge clk);
    check_eq("mid_rst_grant_before", {31'd0, grant_host}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_grant", {31'd0, grant_host}, 32'd0);
    check_eq("mid_rst_ack", {31'd0, host_ack}, 32'd0);
    check_eq("mid_rst_rdata", host_rdata, 32'd0);
    check_eq("mid_rst_mem_write", {31'd0, mem_write}, 32'd0);
    host_req = 1'b0;
    host_we  = 1'b0;
    step();
    word = mem[8'h14];
    check_eq("mid_rst_mem_kept", word, 32'h11111111);
    check_eq("mid_rst_write_cnt", write_cnt - wc0, 32'd0);
    rst = 1'b1;
    step();
    @(negedge clk);
    check_eq("post_rst_ack", {31'd0, host_ack}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
